// File: rtl/reg_dump_streamer.sv
// Register-file dump streamer: freezes the core and emits a framed byte
// stream (header, register bytes MSB-first, XOR checksum) over valid/ready.
module reg_dump_streamer #(
    parameter int DataWidth = 16,
    parameter int NumRegs = 8,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter logic [7:0] HeaderByte = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dumpReq,
    output logic                  busy,
    output logic                  cpuHold,
    output logic [IndexWidth-1:0] readAddr,
    input  logic [DataWidth-1:0]  readData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [7:0]            outData,
    output logic                  outLast
);
    localparam int NumBytes = DataWidth / 8;
    localparam int CntWidth = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IndexWidth-1:0] LastIndex = IndexWidth'(NumRegs - 1);
    localparam logic [CntWidth-1:0] CntInit = CntWidth'(NumBytes - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        SEND,
        CHECKSUM
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IndexWidth-1:0] index;
    logic [CntWidth-1:0]   byte_cnt;
    logic [DataWidth-1:0]  shift_reg;
    logic [7:0]            checksum;
    logic [7:0]            top_byte;

    assign top_byte = shift_reg[DataWidth-1 -: 8];
    assign busy     = (state != IDLE);
    assign cpuHold  = busy;

    always_comb begin
        state_next = state;
        outValid   = 1'b0;
        outLast    = 1'b0;
        outData    = 8'h00;
        readAddr   = '0;
        unique case (state)
            IDLE: begin
                if (dumpReq) state_next = HEADER;
            end
            HEADER: begin
                outValid = 1'b1;
                outData  = HeaderByte;
                if (outReady) state_next = LOAD;
            end
            LOAD: begin
                readAddr   = index;
                state_next = SEND;
            end
            SEND: begin
                readAddr = index;
                outValid = 1'b1;
                outData  = top_byte;
                if (outReady && byte_cnt == '0) begin
                    state_next = (index == LastIndex) ? CHECKSUM : LOAD;
                end
            end
            CHECKSUM: begin
                outValid = 1'b1;
                outLast  = 1'b1;
                outData  = checksum;
                if (outReady) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            index     <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
            checksum  <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (dumpReq) begin
                        index    <= '0;
                        checksum <= 8'h00;
                    end
                end
                LOAD: begin
                    // Register 0 is architecturally zero whatever the port returns
                    shift_reg <= (index == '0) ? '0 : readData;
                    byte_cnt  <= CntInit;
                end
                SEND: begin
                    if (outReady) begin
                        checksum  <= checksum ^ top_byte;
                        shift_reg <= shift_reg << 8;
                        byte_cnt  <= byte_cnt - CntWidth'(1);
                        if (byte_cnt == '0 && index != LastIndex) begin
                            index <= index + IndexWidth'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_streamer.sv
// Bench for reg_dump_streamer: directed steps with randomized backpressure
// and register contents, checked against a frame-level reference model.
module tb_reg_dump_streamer;
    logic        clk;
    logic        rst;
    logic        dumpReq;
    logic        busy;
    logic        cpuHold;
    logic [2:0]  readAddr;
    logic [15:0] readData;
    logic        outValid;
    logic        outReady;
    logic [7:0]  outData;
    logic        outLast;

    logic [15:0] regs [8];
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    int          checks;
    int          errors;
    int          busy_cnt;
    int          hold_bad;
    int          first_cyc;
    bit          done;

    reg_dump_streamer dut (
        .clk      (clk),
        .rst      (rst),
        .dumpReq  (dumpReq),
        .busy     (busy),
        .cpuHold  (cpuHold),
        .readAddr (readAddr),
        .readData (readData),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .outLast  (outLast)
    );

    assign readData = regs[readAddr];

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame built directly from the register values
    task automatic build_exp();
        logic [7:0]  cs;
        logic [15:0] v;
        logic [7:0]  b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int i = 0; i < 8; i++) begin
            v = (i == 0) ? 16'h0000 : regs[i];
            for (int k = 1; k >= 0; k--) begin
                b = 8'((v >> (8 * k)) & 16'h00FF);
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic run_frame(input int pct, input int abort_n,
                             input bit mid_req, input bit hold,
                             input bit skip_start);
        int         cyc;
        bit         ready;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        got_q.delete();
        busy_cnt   = 0;
        hold_bad   = 0;
        first_cyc  = -1;
        done       = 0;
        cyc        = 0;
        prev_stall = 0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        if (!skip_start) begin
            @(negedge clk);
            dumpReq = 1'b1;
        end
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!hold) dumpReq = mid_req && (got_q.size() == 7);
            if (busy) busy_cnt++;
            if (prev_stall && (!outValid || outData !== prev_data ||
                               outLast !== prev_last)) hold_bad++;
            ready = ($urandom_range(99) < pct);
            outReady = ready;
            if (outValid && ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                got_q.push_back(outData);
                if (outLast) done = 1;
                if (abort_n > 0 && got_q.size() == abort_n) begin
                    rst     = 1'b1;
                    dumpReq = 1'b0;
                    done    = 1;
                end
            end
            prev_stall = outValid && !ready;
            prev_data  = outData;
            prev_last  = outLast;
        end
        check("frame_done", 32'(done), 32'd1);
    endtask

    task automatic compare_frame(input string tag);
        logic [8:0] obs;
        build_exp();
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got_q.size()) ? {1'b0, got_q[i]} : 9'h1FF;
            check($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(exp_q[i]));
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        dumpReq  = 1'b0;
        outReady = 1'b0;
        checks   = 0;
        errors   = 0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        regs[1] = 16'h1234;
        regs[2] = 16'h00FF;
        regs[7] = 16'h0010;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hold", 32'(cpuHold), 32'd0);
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_last", 32'(outLast), 32'd0);
        check("rst_data", 32'(outData), 32'd0);
        check("rst_addr", 32'(readAddr), 32'd0);
        rst = 1'b0;

        run_frame(100, 0, 0, 0, 0);
        compare_frame("basic");
        check("basic_cs", 32'(got_q.size() == 18 ? got_q[17] : 8'h00), 32'hC9);
        check("basic_busy_cycles", busy_cnt, 26);

        regs[0] = 16'hBEEF;
        run_frame(100, 0, 0, 0, 0);
        compare_frame("zero");
        check("zero_cs", 32'(got_q.size() == 18 ? got_q[17] : 8'h00), 32'hC9);

        run_frame(30, 0, 0, 0, 0);
        compare_frame("bp");
        check("bp_stable", hold_bad, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
            run_frame(int'($urandom_range(100, 20)), 0, 0, 0, 0);
            compare_frame($sformatf("rand%0d", r));
            check($sformatf("rand%0d_stable", r), hold_bad, 0);
        end

        regs[0] = 16'h0000;
        regs[1] = 16'h1234;
        regs[2] = 16'h00FF;
        for (int i = 3; i < 7; i++) regs[i] = 16'h0000;
        regs[7] = 16'h0010;
        run_frame(100, 0, 1, 0, 0);
        compare_frame("midreq");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midreq_idle_busy", 32'(busy), 32'd0);
            check("midreq_idle_valid", 32'(outValid), 32'd0);
        end

        run_frame(100, 5, 0, 0, 0);
        @(negedge clk);
        check("abort_valid", 32'(outValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(readAddr), 32'd0);
        rst = 1'b0;
        run_frame(60, 0, 0, 0, 0);
        compare_frame("after_abort");

        run_frame(100, 0, 0, 1, 0);
        compare_frame("cont1");
        @(negedge clk);
        check("cont_gap_busy", 32'(busy), 32'd0);
        run_frame(100, 0, 0, 1, 1);
        check("cont_gap_len", first_cyc, 1);
        compare_frame("cont2");
        @(negedge clk);
        dumpReq = 1'b0;
        repeat (3) @(negedge clk);
        check("cont_end_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
- Debug-side reader for the CPU register file.
- On request, it freezes the core and reads every register in turn through a dedicated register-file read port.
- It serialises the register contents as a framed byte stream (header, register bytes MSB-first, XOR checksum) over a valid/ready interface toward the debug link/UART transmitter.
- It sits between the register file's debug read port and the host-facing byte link.

Parameters:
- DataWidth, 16: register width in bits; must be a multiple of 8.
- NumRegs, 8: number of registers dumped (index 0..NumRegs-1).
- IndexWidth, $clog2(NumRegs): register address width.
- HeaderByte, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- dumpReq  input  1  single-cycle or level request to start a dump; sampled only in IDLE.
- busy  output  1  high from the cycle after dumpReq is accepted until the checksum byte is accepted.
- cpuHold  output  1  identical to busy; the core gates countEnable/writeEnable with it so the snapshot is consistent.
- readAddr  output  IndexWidth  register index driven to the register-file read port.
- readData  input  DataWidth  combinational read data for readAddr, valid in the same cycle.
- outValid  output  1  outData holds a byte.
- outReady  input  1  sink accepts the byte; transfer occurs when outValid && outReady.
- outData  output  8  stream byte.
- outLast  output  1  high with the checksum byte (final byte of frame).

Behaviour:
- States: IDLE, HEADER, LOAD, SEND, CHECKSUM.
- Reset values: state=IDLE; busy=0, cpuHold=0, outValid=0, outLast=0, outData=0, readAddr=0; internal index, byte counter and checksum cleared.
- IDLE:
  - dumpReq=1 → HEADER next cycle; index=0, checksum=0.
  - dumpReq is ignored in all other states; no queuing.
- HEADER: outValid=1, outData=HeaderByte. On transfer → LOAD. The header is not included in the checksum.
- LOAD (1 cycle, outValid=0):
  - readAddr=index; capture readData into the shift register.
  - If index==0, capture 0 regardless of readData, because the zero register is architecturally 0.
  - Byte counter = DataWidth/8 - 1. Next state SEND.
- SEND:
  - outValid=1, outData = top byte of the shift register.
  - On transfer: XOR the byte into the checksum, shift left 8, decrement the byte counter.
  - After the last byte of a register: if index==NumRegs-1 → CHECKSUM, else index+1 → LOAD.
- CHECKSUM: outValid=1, outLast=1, outData=checksum. On transfer → IDLE; busy/cpuHold/outValid drop at that same edge.
- Output stability:
  - While outValid=1 and outReady=0, outData/outLast hold stable and the state is frozen.
  - outValid is never withdrawn without a transfer.
- readAddr is held at the current index in SEND and at 0 in IDLE/HEADER/CHECKSUM.
- Frame length: 1 + NumRegs*DataWidth/8 + 1 bytes (18 at defaults).
- Minimum busy duration with outReady tied high: 1 + NumRegs*(1+DataWidth/8) + 1 cycles (26 at defaults).
- Reset asserted mid-frame: return to IDLE next edge, outValid=0 immediately after that edge; no partial-frame completion.
- dumpReq held high continuously: a new frame starts the cycle after returning to IDLE, giving back-to-back frames separated by one IDLE cycle.

Test Plan:
- Basic dump (shared by the next two tests): model R1=0x1234, R2=0x00FF, R7=0x0010, others 0; pulse dumpReq with outReady=1.
  → Bytes A5 00 00 12 34 00 FF 00 00 00 00 00 00 00 00 00 10 C9.
  → outLast only on C9; busy high exactly 26 cycles.
- Zero-register forcing: as basic dump, but the model returns 0xBEEF for address 0.
  → Bytes 2-3 remain 00 00; checksum still C9.
- Backpressure: random outReady (~30% high).
  → Identical 18-byte sequence; outData never changes while outValid && !outReady; no duplicated or dropped bytes.
- Request while busy: assert dumpReq again mid-frame.
  → Ignored; exactly one frame emitted, busy falls after C9 is accepted.
- Reset mid-frame: assert rst after 5 bytes accepted.
  → Next cycle outValid=0, busy=0, readAddr=0; a subsequent dumpReq yields a complete frame starting with A5.
- Continuous request: dumpReq held high.
  → Two complete 18-byte frames with exactly one IDLE cycle (busy=0) between the final C9 and the next A5.
